// File: rtl/sram_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM encoding and default read latency.
package sram_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StTurn   = 2'd2
  } arb_state_e;

  localparam int unsigned RdLatDefault = 2;

endpackage

// File: rtl/sram_rd_tag.sv
// Read-tag pipeline: Depth-deep shift register of {valid, port} that tracks reads in flight.
module sram_rd_tag #(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic port_i,
  output logic valid_o,
  output logic port_o
);

  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] port_q, port_d;

  always_comb begin
    valid_d    = valid_q;
    port_d     = port_q;
    valid_d[0] = push_i;
    port_d[0]  = port_i;
    for (int unsigned i = 1; i < Depth; i++) begin
      valid_d[i] = valid_q[i-1];
      port_d[i]  = port_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      port_q  <= '0;
    end else begin
      valid_q <= valid_d;
      port_q  <= port_d;
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign port_o  = port_q[Depth-1];

endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter with registered SRAM bus, write-to-read turnaround and in-order reads.
// Round-robin by default; define SRAM_ARB_P0_PRIO_EN for strict port-0 priority.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned AW     = 19,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = RdLatDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          sram_wren,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q
);

  arb_state_e    state_q;
  logic          wr_prev_q;
  logic          sram_wren_q;
  logic [AW-1:0] sram_addr_q;
  logic [DW-1:0] sram_d_q;
  logic          p0_rvalid_q, p1_rvalid_q;
  logic [DW-1:0] p0_rdata_q, p1_rdata_q;

  logic any_req, win, win_we, turn_needed, gnt;
  logic tag_valid, tag_port;

`ifdef SRAM_ARB_P0_PRIO_EN
  assign win = ~p0_req;
`else
  // Port last granted; reset to port 1 so port 0 wins the first tie.
  logic last_q;

  assign win = (p0_req & p1_req) ? ~last_q : ~p0_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (gnt) begin
      last_q <= win;
    end
  end
`endif

  always_comb begin
    any_req     = p0_req | p1_req;
    win_we      = win ? p1_we : p0_we;
    // A read right behind a write on the bus must wait out one turnaround cycle.
    turn_needed = (state_q == StAccess) && wr_prev_q && any_req && !win_we;
    gnt         = rst_n && any_req && (state_q != StTurn) && !turn_needed;
    p0_gnt      = gnt & ~win;
    p1_gnt      = gnt & win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_prev_q   <= 1'b0;
      sram_wren_q <= 1'b0;
      sram_addr_q <= '0;
      sram_d_q    <= '0;
    end else begin
      wr_prev_q   <= gnt & win_we;
      sram_wren_q <= gnt & win_we;
      if (gnt) begin
        sram_addr_q <= win ? p1_addr : p0_addr;
        sram_d_q    <= win ? p1_wdata : p0_wdata;
      end
      unique case (state_q)
        StIdle: begin
          if (gnt) state_q <= StAccess;
        end
        StAccess: begin
          if (turn_needed) begin
            state_q <= StTurn;
          end else if (!gnt) begin
            state_q <= StIdle;
          end
        end
        StTurn: begin
          state_q <= StAccess;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  sram_rd_tag #(
    .Depth (RD_LAT)
  ) u_rd_tag (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (gnt & ~win_we),
    .port_i  (win),
    .valid_o (tag_valid),
    .port_o  (tag_port)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      p0_rvalid_q <= tag_valid & ~tag_port;
      p1_rvalid_q <= tag_valid & tag_port;
      if (tag_valid && !tag_port) p0_rdata_q <= sram_q;
      if (tag_valid && tag_port)  p1_rdata_q <= sram_q;
    end
  end

  assign sram_wren = sram_wren_q;
  assign sram_addr = sram_addr_q;
  assign sram_d    = sram_d_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM (one-cycle registered read port).
// Unwritten locations read back as addr[7:0] ^ 8'h3C.
module tb_sram_arbiter;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          sram_wren;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_d, sram_q;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0]    mem [1024];
  bit   [1023:0] written;

  always #5 clk = ~clk;

  sram_arbiter #(
    .AW     (AW),
    .DW     (DW),
    .RD_LAT (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .sram_wren (sram_wren),
    .sram_addr (sram_addr),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  always @(posedge clk) begin
    if (sram_wren) begin
      mem[sram_addr[9:0]]     <= sram_d;
      written[sram_addr[9:0]] <= 1'b1;
    end
    sram_q <= written[sram_addr[9:0]] ? mem[sram_addr[9:0]] : (sram_addr[7:0] ^ 8'h3C);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    logic exp_rv;
    written  = '0;
    rst_n    = 1'b0;
    p0_req   = 1'b1;
    p1_req   = 1'b1;
    p0_we    = 1'b0;
    p1_we    = 1'b0;
    p0_addr  = 19'h00010;
    p1_addr  = 19'h00020;
    p0_wdata = 8'h00;
    p1_wdata = 8'h00;

    // Reset with both ports requesting
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    check_eq("rst_p1_gnt", 32'(p1_gnt), 32'd0);
    check_eq("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    check_eq("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
    check_eq("rst_wren", 32'(sram_wren), 32'd0);
    check_eq("rst_addr", 32'(sram_addr), 32'd0);
    check_eq("rst_p0_rdata", 32'(p0_rdata), 32'd0);

    // Tie between two reads: p0 first, then p1, data back in order
    @(negedge clk); rst_n = 1'b1; #1;
    check_eq("tie_c0_p0_gnt", 32'(p0_gnt), 32'd1);
    check_eq("tie_c0_p1_gnt", 32'(p1_gnt), 32'd0);
    @(negedge clk); p0_req = 1'b0; #1;
    check_eq("tie_c1_p1_gnt", 32'(p1_gnt), 32'd1);
    check_eq("tie_c1_p0_gnt", 32'(p0_gnt), 32'd0);
    check_eq("tie_c1_addr", 32'(sram_addr), 32'h10);
    @(negedge clk); p1_req = 1'b0; #1;
    check_eq("tie_c2_addr", 32'(sram_addr), 32'h20);
    check_eq("tie_c2_p0_rvalid", 32'(p0_rvalid), 32'd0);
    @(negedge clk); #1;
    check_eq("tie_c3_p0_rvalid", 32'(p0_rvalid), 32'd1);
    check_eq("tie_c3_p0_rdata", 32'(p0_rdata), 32'h2C);
    check_eq("tie_c3_p1_rvalid", 32'(p1_rvalid), 32'd0);
    @(negedge clk); #1;
    check_eq("tie_c4_p1_rvalid", 32'(p1_rvalid), 32'd1);
    check_eq("tie_c4_p1_rdata", 32'(p1_rdata), 32'h1C);
    check_eq("tie_c4_p0_rvalid", 32'(p0_rvalid), 32'd0);
    check_eq("tie_c4_p0_rdata_hold", 32'(p0_rdata), 32'h2C);

    // Write 0xA5 to the top address, then read it back through one TURN cycle
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 19'h7FFFF; p0_wdata = 8'hA5;
    #1;
    check_eq("turn_wr_gnt", 32'(p0_gnt), 32'd1);
    @(negedge clk); p0_we = 1'b0; #1;
    check_eq("turn_hold_gnt", 32'(p0_gnt), 32'd0);
    check_eq("turn_wr_wren", 32'(sram_wren), 32'd1);
    check_eq("turn_wr_addr", 32'(sram_addr), 32'h7FFFF);
    check_eq("turn_wr_d", 32'(sram_d), 32'hA5);
    @(negedge clk); #1;
    check_eq("turn_bubble_gnt", 32'(p0_gnt), 32'd0);
    check_eq("turn_bubble_wren", 32'(sram_wren), 32'd0);
    @(negedge clk); #1;
    check_eq("turn_rd_gnt", 32'(p0_gnt), 32'd1);
    @(negedge clk); p0_req = 1'b0; #1;
    check_eq("turn_rd_wren", 32'(sram_wren), 32'd0);
    check_eq("turn_rd_addr", 32'(sram_addr), 32'h7FFFF);
    check_eq("turn_early_rvalid", 32'(p0_rvalid), 32'd0);
    @(negedge clk); #1;
    check_eq("turn_early_rvalid2", 32'(p0_rvalid), 32'd0);
    @(negedge clk); #1;
    check_eq("turn_rvalid", 32'(p0_rvalid), 32'd1);
    check_eq("turn_rdata", 32'(p0_rdata), 32'hA5);

    // p1 streams 16 reads with no bubbles
    p1_we = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k < 16) begin
        p1_req  = 1'b1;
        p1_addr = 19'(32'h100 + k);
      end else begin
        p1_req = 1'b0;
      end
      #1;
      if (k < 16) begin
        check_eq($sformatf("stream_gnt_%0d", k), 32'(p1_gnt), 32'd1);
      end
      exp_rv = (k >= 3) && (k < 19);
      check_eq($sformatf("stream_rvalid_%0d", k), 32'(p1_rvalid), 32'(exp_rv));
      if (exp_rv) begin
        check_eq($sformatf("stream_rdata_%0d", k - 3), 32'(p1_rdata),
                 32'(8'(k - 3) ^ 8'h3C));
      end
    end
    check_eq("stream_p0_gnt", 32'(p0_gnt), 32'd0);

    // Read -> write -> write, all without bubbles
    @(negedge clk); p1_req = 1'b1; p1_we = 1'b0; p1_addr = 19'h30; #1;
    check_eq("rw_rd_gnt", 32'(p1_gnt), 32'd1);
    @(negedge clk); p1_we = 1'b1; p1_wdata = 8'h5A; #1;
    check_eq("rw_wr1_gnt", 32'(p1_gnt), 32'd1);
    @(negedge clk); p1_addr = 19'h31; p1_wdata = 8'hC3; #1;
    check_eq("rw_wr2_gnt", 32'(p1_gnt), 32'd1);
    check_eq("rw_wr1_wren", 32'(sram_wren), 32'd1);
    check_eq("rw_wr1_addr", 32'(sram_addr), 32'h30);
    check_eq("rw_wr1_d", 32'(sram_d), 32'h5A);
    @(negedge clk); p1_req = 1'b0; #1;
    check_eq("rw_wr2_wren", 32'(sram_wren), 32'd1);
    check_eq("rw_wr2_addr", 32'(sram_addr), 32'h31);
    check_eq("rw_wr2_d", 32'(sram_d), 32'hC3);
    check_eq("rw_rd_rvalid", 32'(p1_rvalid), 32'd1);
    check_eq("rw_rd_rdata", 32'(p1_rdata), 32'h0C);

    // Reset one cycle after a read grant: the read must never return
    @(negedge clk); p0_req = 1'b1; p0_we = 1'b0; p0_addr = 19'h40; #1;
    check_eq("rmid_gnt", 32'(p0_gnt), 32'd1);
    @(negedge clk); p0_req = 1'b0; rst_n = 1'b0; #1;
    check_eq("rmid_addr", 32'(sram_addr), 32'd0);
    check_eq("rmid_rvalid_in_rst", 32'(p0_rvalid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq($sformatf("rmid_rvalid_%0d", k), 32'(p0_rvalid), 32'd0);
      @(negedge clk);
    end

    // Both ports hold read requests for 4 cycles
    p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b0; p1_we = 1'b0;
    p0_addr = 19'h50; p1_addr = 19'h60;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef SRAM_ARB_P0_PRIO_EN
      check_eq($sformatf("prio_p0_gnt_%0d", k), 32'(p0_gnt), 32'd1);
      check_eq($sformatf("prio_p1_gnt_%0d", k), 32'(p1_gnt), 32'd0);
`else
      check_eq($sformatf("rr_p0_gnt_%0d", k), 32'(p0_gnt), 32'((k % 2) == 0));
      check_eq($sformatf("rr_p1_gnt_%0d", k), 32'(p1_gnt), 32'((k % 2) == 1));
`endif
      @(negedge clk);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
